// File: rtl/mem_write_controller.sv
// mem_write_controller: round-robin arbiter of consumer write requests onto memory write channels
// Ports:
//   clk, reset (sync, active-low)
//   consumer_write_valid/address/data : per-consumer held requests (packed by consumer)
//   consumer_write_ready               : one-cycle completion pulse per consumer
//   mem_write_valid/address/data       : per-channel memory write requests (packed by channel)
//   mem_write_ready                    : per-channel memory acknowledge
module mem_write_controller #(
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 2,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CONSUMERS-1:0]          consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]          consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]           mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_ready
);
  localparam int CW = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;
  typedef enum logic [1:0] {IDLE, WRITE_WAITING, RELAYING, RELEASE} state_t;
  state_t                          state_q [NUM_CHANNELS];
  state_t                          state_d [NUM_CHANNELS];
  logic [CW-1:0]                   cur_q [NUM_CHANNELS];
  logic [CW-1:0]                   cur_d [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]        busy_q, busy_d, rdy_q, rdy_d, claim;
  logic [NUM_CHANNELS-1:0]         mv_q, mv_d;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] ma_q, ma_d;
  logic [NUM_CHANNELS*DATA_BITS-1:0] md_q, md_d;
  logic [CW-1:0]                   rr_q, rr_d, sel, cand;
  logic                            found;
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    busy_d  = busy_q;
    rdy_d   = '0;
    mv_d    = mv_q;
    ma_d    = ma_q;
    md_d    = md_q;
    rr_d    = rr_q;
    claim   = busy_q;
    sel     = '0;
    cand    = '0;
    found   = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      case (state_q[c])
        IDLE: begin
          // claim accumulates grants of lower channels so each consumer is taken once per cycle
          found = 1'b0;
          sel   = '0;
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
            cand = CW'((int'(rr_q) + k) % NUM_CONSUMERS);
            if (!found && consumer_write_valid[cand] && !claim[cand]) begin
              found = 1'b1;
              sel   = cand;
            end
          end
          if (found) begin
            claim[sel]                      = 1'b1;
            busy_d[sel]                     = 1'b1;
            cur_d[c]                        = sel;
            mv_d[c]                         = 1'b1;
            ma_d[c*ADDR_BITS +: ADDR_BITS]  = consumer_write_address[sel*ADDR_BITS +: ADDR_BITS];
            md_d[c*DATA_BITS +: DATA_BITS]  = consumer_write_data[sel*DATA_BITS +: DATA_BITS];
            // later channels grant later in scan order, so the last grant sets the pointer
            rr_d                            = CW'((int'(sel) + 1) % NUM_CONSUMERS);
            state_d[c]                      = WRITE_WAITING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[c]) begin
            mv_d[c]          = 1'b0;
            rdy_d[cur_q[c]]  = 1'b1;
            state_d[c]       = RELAYING;
          end
        end
        RELAYING: state_d[c] = RELEASE;
        default: begin
          if (!consumer_write_valid[cur_q[c]]) begin
            busy_d[cur_q[c]] = 1'b0;
            state_d[c]       = IDLE;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= '{default: IDLE};
      cur_q   <= '{default: '0};
      busy_q  <= '0;
      rdy_q   <= '0;
      mv_q    <= '0;
      ma_q    <= '0;
      md_q    <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      mv_q    <= mv_d;
      ma_q    <= ma_d;
      md_q    <= md_d;
      rr_q    <= rr_d;
    end
  end
  assign consumer_write_ready = rdy_q;
  assign mem_write_valid      = mv_q;
  assign mem_write_address    = ma_q;
  assign mem_write_data       = md_q;
endmodule

// File: tb/tb_mem_write_controller.sv
// tb_mem_write_controller: directed and randomized self-checking bench for mem_write_controller
module tb_mem_write_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cv, cr;
  logic [31:0] ca, cd;
  logic [1:0]  mv, mr;
  logic [15:0] ma, md;
  logic [3:0]  v1, r1;
  logic [31:0] a1, d1;
  logic [0:0]  mv1, mr1;
  logic [7:0]  ma1, md1;
  int          total = 0;
  int          bad = 0;
  bit          pend [4];
  bit          ackd [4];
  int          cool [4];
  logic [7:0]  ra [4];
  logic [7:0]  rd [4];
  logic [3:0]  exp_r;
  logic [1:0]  pmv, pmr;
  logic [15:0] pma, pmd;
  int          issued, done_n, j;
  always #5 clk = ~clk;
  mem_write_controller #(.NUM_CONSUMERS(4), .NUM_CHANNELS(2), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .consumer_write_valid(cv), .consumer_write_address(ca), .consumer_write_data(cd),
    .consumer_write_ready(cr),
    .mem_write_valid(mv), .mem_write_address(ma), .mem_write_data(md), .mem_write_ready(mr)
  );
  mem_write_controller #(.NUM_CONSUMERS(4), .NUM_CHANNELS(1), .ADDR_BITS(8), .DATA_BITS(8)) dut1 (
    .clk(clk), .reset(reset),
    .consumer_write_valid(v1), .consumer_write_address(a1), .consumer_write_data(d1),
    .consumer_write_ready(r1),
    .mem_write_valid(mv1), .mem_write_address(ma1), .mem_write_data(md1), .mem_write_ready(mr1)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b0;
    cv = '0;
    v1 = '0;
    mr = '0;
    mr1 = '0;
    tick;
    tick;
    reset = 1'b1;
  endtask
  initial begin
    reset = 1'b0; cv = '0; ca = '0; cd = '0; mr = '0;
    v1 = '0; a1 = '0; d1 = '0; mr1 = '0;
    tick;
    tick;
    chk("rst_ready", cr, 0);
    chk("rst_mv", mv, 0);
    chk("rst_ma", ma, 0);
    chk("rst_md", md, 0);
    reset = 1'b1;
    cv = 4'b0001; ca[7:0] = 8'h12; cd[7:0] = 8'hAB;
    tick;
    chk("t1_mv", mv, 2'b01);
    chk("t1_ma", ma[7:0], 8'h12);
    chk("t1_md", md[7:0], 8'hAB);
    chk("t1_no_ready", cr, 0);
    mr = 2'b01;
    tick;
    chk("t1_ack_mv", mv, 0);
    chk("t1_ready", cr, 4'b0001);
    cv = '0; mr = '0;
    tick;
    chk("t1_pulse_end", cr, 0);
    chk("t1_ch1_untouched", {mv[1], ma[15:8], md[15:8]}, 0);
    tick;
    do_reset;
    for (int k = 0; k < 4; k++) begin
      ca[k*8 +: 8] = 8'(32'h20 + k);
      cd[k*8 +: 8] = 8'(32'h40 + k);
    end
    cv = 4'b1111; mr = 2'b11;
    tick;
    chk("t2_g1_mv", mv, 2'b11);
    chk("t2_g1_ma", ma, 16'h2120);
    chk("t2_g1_md", md, 16'h4140);
    tick;
    chk("t2_a1_ready", cr, 4'b0011);
    chk("t2_a1_mv", mv, 0);
    cv = 4'b1100;
    tick;
    chk("t2_relay_ready", cr, 0);
    tick;
    chk("t2_release_mv", mv, 0);
    tick;
    chk("t2_g2_mv", mv, 2'b11);
    chk("t2_g2_ma", ma, 16'h2322);
    chk("t2_g2_md", md, 16'h4342);
    tick;
    chk("t2_a2_ready", cr, 4'b1100);
    cv = '0; mr = '0;
    tick;
    chk("t2_end_ready", cr, 0);
    tick;
    tick;
    do_reset;
    a1[7:0] = 8'h30; d1[7:0] = 8'h50; a1[31:24] = 8'h33; d1[31:24] = 8'h53;
    v1 = 4'b1001; mr1 = 1'b1;
    tick;
    chk("t3_first_c0", {mv1, ma1, md1}, {1'b1, 8'h30, 8'h50});
    tick;
    chk("t3_c0_ready", r1, 4'b0001);
    v1 = 4'b1000;
    tick;
    tick;
    v1 = 4'b1001;
    tick;
    chk("t3_c3_before_c0", {mv1, ma1, md1}, {1'b1, 8'h33, 8'h53});
    tick;
    chk("t3_c3_ready", r1, 4'b1000);
    v1 = 4'b0001;
    tick;
    tick;
    tick;
    chk("t3_c0_second", {mv1, ma1}, {1'b1, 8'h30});
    tick;
    chk("t3_c0_ready2", r1, 4'b0001);
    v1 = '0; mr1 = '0;
    tick;
    tick;
    do_reset;
    cv = 4'b0100; ca[23:16] = 8'h5A; cd[23:16] = 8'hC3; mr = '0;
    tick;
    for (int k = 0; k < 10; k++) begin
      chk("t4_stall_hold", {cr, mv, ma[7:0], md[7:0]}, {4'b0000, 2'b01, 8'h5A, 8'hC3});
      tick;
    end
    mr = 2'b01;
    tick;
    chk("t4_ack_ready", {cr, mv}, {4'b0100, 2'b00});
    cv = '0; mr = '0;
    tick;
    chk("t4_pulse_end", cr, 0);
    tick;
    mr = 2'b10;
    tick;
    chk("t5_stray_idle", {cr, mv}, 0);
    mr = '0; cv = 4'b0010; ca[15:8] = 8'h77; cd[15:8] = 8'h99;
    tick;
    chk("t5_grant", {mv, ma[7:0], md[7:0]}, {2'b01, 8'h77, 8'h99});
    mr = 2'b10;
    tick;
    chk("t5_stray_busy", {cr, mv}, {4'b0000, 2'b01});
    mr = 2'b01;
    tick;
    chk("t5_ready", cr, 4'b0010);
    cv = '0; mr = '0;
    tick;
    tick;
    cv = 4'b0010;
    tick;
    chk("t6_grant", mv, 2'b01);
    reset = 1'b0; cv = '0;
    tick;
    chk("t6_reset_outputs", {cr, mv, ma, md}, 0);
    reset = 1'b1;
    ca[7:0] = 8'h0A; cd[7:0] = 8'h1A; ca[31:24] = 8'h3A; cd[31:24] = 8'h4A;
    cv = 4'b1001;
    tick;
    chk("t6_rr_zero", {mv, ma}, {2'b11, 16'h3A0A});
    mr = 2'b11;
    tick;
    chk("t6_ready", cr, 4'b1001);
    cv = '0; mr = '0;
    tick;
    tick;
    do_reset;
    issued = 0; done_n = 0;
    for (int k = 0; k < 4; k++) begin
      pend[k] = 0; ackd[k] = 0; cool[k] = 0; ra[k] = '0; rd[k] = '0;
    end
    pmv = '0; pmr = '0; pma = '0; pmd = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick;
      exp_r = '0;
      for (int c = 0; c < 2; c++) begin
        if (pmv[c] && pmr[c]) begin
          j = int'(pma[c*8+6 +: 2]);
          chk("rnd_ack_owner", {pend[j], ackd[j], pma[c*8 +: 8], pmd[c*8 +: 8]}, {1'b1, 1'b0, ra[j], rd[j]});
          ackd[j] = 1;
          exp_r[j] = 1'b1;
        end
      end
      chk("rnd_ready", cr, exp_r);
      for (int k = 0; k < 4; k++) begin
        if (exp_r[k]) begin
          pend[k] = 0;
          cool[k] = $urandom_range(1, 4);
          done_n++;
        end
      end
      for (int c = 0; c < 2; c++) begin
        if (mv[c]) begin
          j = int'(ma[c*8+6 +: 2]);
          chk("rnd_live", {pend[j], ackd[j], ma[c*8 +: 8], md[c*8 +: 8]}, {1'b1, 1'b0, ra[j], rd[j]});
        end
      end
      if (mv == 2'b11) chk("rnd_exclusive", ma[7:6] != ma[15:14], 1);
      for (int k = 0; k < 4; k++) begin
        if (!pend[k] && !exp_r[k]) begin
          if (cool[k] > 0) cool[k]--;
          else if (cyc < 2500 && $urandom_range(0, 2) == 0) begin
            pend[k] = 1;
            ackd[k] = 0;
            ra[k] = {2'(k), 6'($urandom)};
            rd[k] = 8'($urandom);
            issued++;
          end
        end
        cv[k] = pend[k];
        ca[k*8 +: 8] = ra[k];
        cd[k*8 +: 8] = rd[k];
      end
      mr = 2'($urandom);
      pmv = mv; pmr = mr; pma = ma; pmd = md;
    end
    chk("rnd_drained", done_n, issued);
    chk("rnd_idle", {cv, mv, cr}, 0);
    chk("rnd_activity", issued > 100, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_write_controller.md
# mem_write_controller

Write-side memory controller between the per-thread store LSUs and the data-memory write channels. Collects up to NUM_CONSUMERS simultaneous write requests (valid/address/data held until acknowledged), arbitrates them round-robin onto NUM_CHANNELS memory write channels, forwards each write, and returns a one-cycle ready pulse to the originating consumer once memory acknowledges. Every consumer write is issued to memory exactly once, with no duplicates and no drops.

## Interface
- NUM_CONSUMERS, 4, number of requesting LSUs (≥1)
- NUM_CHANNELS, 2, number of memory write channels (1..NUM_CONSUMERS)
- ADDR_BITS, 8, address width
- DATA_BITS, 8, data width
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset, sampled on rising edge of clk)
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer request, held until ready seen
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed, consumer j at [j*ADDR_BITS +: ADDR_BITS]
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed likewise
- consumer_write_ready  out  NUM_CONSUMERS  one-cycle completion pulse per consumer
- mem_write_valid  out  NUM_CHANNELS  per-channel write request
- mem_write_address  out  NUM_CHANNELS*ADDR_BITS  packed, channel c at [c*ADDR_BITS +: ADDR_BITS]
- mem_write_data  out  NUM_CHANNELS*DATA_BITS  packed likewise
- mem_write_ready  in  NUM_CHANNELS  memory acknowledge per channel

## Operation
- Per-channel FSM: IDLE, WRITE_WAITING, RELAYING, RELEASE. Per-channel register current_consumer. Global bitmask consumer_busy[NUM_CONSUMERS]. Round-robin pointer rr_ptr (log2 NUM_CONSUMERS bits, minimum 1).
- IDLE: channel selects the first consumer j, scanning from rr_ptr upward modulo NUM_CONSUMERS, with consumer_write_valid[j]=1 and consumer_busy[j]=0. Channels are evaluated in ascending index within a cycle, and a consumer claimed by a lower channel in the same cycle is not eligible. On grant, latch address/data into mem_write_address/data[c], set mem_write_valid[c]=1, set consumer_busy[j]=1, set current_consumer[c]=j, go to WRITE_WAITING.
- rr_ptr update: if any grant occurred this cycle, rr_ptr becomes (highest-order grant in scan order + 1) mod NUM_CONSUMERS. Otherwise it is unchanged.
- WRITE_WAITING: hold valid/address/data stable. On mem_write_ready[c]=1: mem_write_valid[c]=0, consumer_write_ready[current_consumer]=1, go to RELAYING.
- RELAYING: consumer_write_ready[current_consumer]=0 unconditionally, go to RELEASE.
- RELEASE: when consumer_write_valid[current_consumer]=0, clear consumer_busy[current_consumer] and go to IDLE. Otherwise stay.
- mem_write_ready[c] is ignored outside WRITE_WAITING.
- consumer_write_valid dropping during WRITE_WAITING is ignored: the write still completes and the ready pulse is still sent.
- Address/data outputs keep their last value after completion; they are meaningful only while mem_write_valid is 1.

## Timing
- Reset (reset=0 at an edge): all FSMs go to IDLE. consumer_busy=0, rr_ptr=0, current_consumer=0. All outputs are 0: consumer_write_ready, mem_write_valid, mem_write_address, mem_write_data.
- Reset mid-operation: in-flight writes are abandoned, with no ready pulse. The memory must tolerate valid dropping without ack.
- Grant latency: consumer valid sampled high at edge E gives mem_write_valid high after E.
- Ack: mem_write_ready sampled at edge A gives consumer ready high for exactly the cycle after A, and mem_write_valid low after A.
- With an LSU that drops valid on the edge where it samples ready, RELEASE exits one edge later. The earliest re-grant of the same consumer is 3 edges after A.
- Minimum per-write occupancy of a channel: 4 cycles with zero-wait memory (grant, wait, relay, release).
- Simultaneous ack on multiple channels: each pulses its own consumer independently in the same cycle.
- At most one channel serves a given consumer at any time, and consumer_write_ready is never high for more than one consecutive cycle.

## Test plan
- Single write: reset, then consumer 0 valid with addr 0x12 and data 0xAB, memory acks 1 cycle after valid. Required: mem_write_valid[0] with 0x12/0xAB, one ready pulse on consumer 0, channel 1 untouched.
- All 4 consumers request at once with NUM_CHANNELS=2 and zero-wait memory. Required: first grants are consumers 0→ch0 and 1→ch1, next grants are 2 and 3. Exactly 4 memory writes occur with correct addr/data pairs and one ready pulse each.
- Fairness: consumer 0 re-requests immediately after each completion while consumer 3 is continuously valid, NUM_CHANNELS=1. Required: consumer 3 is granted before consumer 0's second grant.
- Memory stall: hold mem_write_ready low for 10 cycles. Required: valid/addr/data are stable throughout, no consumer ready occurs, and the ready pulse comes one cycle after ack.
- Stray ack: pulse mem_write_ready[1] while channel 1 is IDLE. Required: no consumer_write_ready and no state change.
- Reset mid-operation: assert reset=0 while in WRITE_WAITING. Required: all outputs are 0 next cycle, and after release a fresh request is granted normally with rr_ptr=0.
